// File: rtl/any1_agen_seq.sv
// Multi-element memory-op sequencer: walks element indices for the registered
// address generator and issues one req/ack memory request per active element.
// Optional mask skipping is enabled by defining ANY1_AGEN_SEQ_MASK_EN.
module any1_agen_seq #(
  parameter int NELEM = 64,
  parameter int STEPW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [STEPW:0]   vl_i,
  input  logic [NELEM-1:0] mask_i,
  input  logic             abort_i,
  input  logic             mem_ack_i,
  output logic [STEPW-1:0] step_o,
  output logic             mem_req_o,
  output logic             mem_last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHK   = 3'd1;
  localparam logic [2:0] S_AGEN  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [STEPW:0]   VL_MAX   = (STEPW+1)'(NELEM);
  localparam logic [STEPW:0]   VL_ONE   = (STEPW+1)'(1);
  localparam logic [STEPW-1:0] STEP_ONE = STEPW'(1);

  logic [2:0]       state_q, state_d;
  logic [STEPW-1:0] step_q, step_d;
  logic [STEPW:0]   vl_q;
  logic [STEPW:0]   vl_clamp;
  logic             start_ok;
  logic             at_last;
  logic             elem_active;

  // Oversized vector lengths saturate to the hardware maximum.
  assign vl_clamp = (vl_i > VL_MAX) ? VL_MAX : vl_i;
  assign start_ok = (state_q == S_IDLE) && start_i && !abort_i;
  assign at_last  = (({1'b0, step_q} + VL_ONE) == vl_q);

`ifdef ANY1_AGEN_SEQ_MASK_EN
  logic [NELEM-1:0] mask_q;

  // NOTE: mask_q has no reset; it is always written at start before CHK reads it,
  // so leaving it out of reset keeps the register file reset-free.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      mask_q <= mask_i;
    end
  end

  assign elem_active = mask_q[step_q];
`else
  logic mask_unused;

  assign mask_unused = ^mask_i;
  assign elem_active = 1'b1;
`endif

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (abort_i) begin
      state_d = S_IDLE;
      step_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            step_d  = '0;
            state_d = (vl_clamp == '0) ? S_DONE : S_CHK;
          end
        end
        S_CHK: begin
          if (elem_active) begin
            state_d = S_AGEN;
          end else if (at_last) begin
            state_d = S_DONE;
          end else begin
            step_d = step_q + STEP_ONE;
          end
        end
        // One cycle for the generator to register EA from the held step.
        S_AGEN: state_d = S_ISSUE;
        S_ISSUE: begin
          if (mem_ack_i) begin
            if (at_last) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CHK;
              step_d  = step_q + STEP_ONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      vl_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (start_ok) begin
        vl_q <= vl_clamp;
      end
    end
  end

  assign step_o     = step_q;
  assign mem_req_o  = (state_q == S_ISSUE);
  assign mem_last_o = mem_req_o && at_last;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_any1_agen_seq.sv
// Self-checking bench for any1_agen_seq; compares against a queue-based model
// of which element indices should be requested. Honours ANY1_AGEN_SEQ_MASK_EN.
module tb_any1_agen_seq;

`ifdef ANY1_AGEN_SEQ_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [6:0]  vl_i;
  logic [63:0] mask_i;
  logic        abort_i;
  logic        mem_ack_i;
  logic [5:0]  step_o;
  logic        mem_req_o;
  logic        mem_last_o;
  logic        busy_o;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;

  any1_agen_seq #(.NELEM(64), .STEPW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .vl_i       (vl_i),
    .mask_i     (mask_i),
    .abort_i    (abort_i),
    .mem_ack_i  (mem_ack_i),
    .step_o     (step_o),
    .mem_req_o  (mem_req_o),
    .mem_last_o (mem_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; vl_i = '0; mask_i = '0; abort_i = 1'b0; mem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (step_o !== 6'd0) begin n_fail++; $display("FAIL reset_step got=%0d exp=0", step_o); end
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_req_o); end
    n_tests++; if (mem_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", mem_last_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // VL=1 with ack held high: request at +3, done at +4, idle at +5.
  task automatic test_latency();
    start_i = 1'b1; vl_i = 7'd1; mask_i = 64'd1; mem_ack_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      n_tests++; if (mem_req_o !== (cyc == 3)) begin n_fail++; $display("FAIL latency_req cyc=%0d got=%b exp=%b", cyc, mem_req_o, cyc == 3); end
      n_tests++; if (done_o !== (cyc == 4)) begin n_fail++; $display("FAIL latency_done cyc=%0d got=%b exp=%b", cyc, done_o, cyc == 4); end
      n_tests++; if (busy_o !== (cyc < 5)) begin n_fail++; $display("FAIL latency_busy cyc=%0d got=%b exp=%b", cyc, busy_o, cyc < 5); end
      if (cyc == 3) begin
        n_tests++; if (step_o !== 6'd0) begin n_fail++; $display("FAIL latency_step got=%0d exp=0", step_o); end
        n_tests++; if (mem_last_o !== 1'b1) begin n_fail++; $display("FAIL latency_last got=%b exp=1", mem_last_o); end
      end
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
  endtask

  // Generic sequence driver. The model is the ordered list of element indices
  // that must be requested; ack latency is drawn from [min_d, max_d].
  task automatic run_seq(input string name, input int vl, input logic [63:0] mask,
                         input int min_d, input int max_d, input bit noise_ack,
                         input bit poke_start);
    int          exp_q[$];
    int          vlc;
    int          n_req;
    int          n_done;
    int          wait_cnt;
    int          delay;
    bit          in_req;
    bit          finished;
    logic [5:0]  held_step;

    vlc = (vl > 64) ? 64 : vl;
    for (int i = 0; i < vlc; i++) begin
      if (!MASK_EN || mask[i]) exp_q.push_back(i);
    end
    n_req = 0; n_done = 0; in_req = 1'b0; finished = 1'b0; wait_cnt = 0; delay = 0; held_step = '0;

    start_i = 1'b1; vl_i = 7'(vl); mask_i = mask;
    @(negedge clk);
    for (int cyc = 1; cyc < 5000; cyc++) begin
      mem_ack_i = 1'b0;
      start_i   = poke_start && (cyc == 2);
      if (poke_start && cyc == 2) begin
        vl_i = 7'd5; mask_i = '1;
      end
      if (!busy_o) begin
        finished = 1'b1;
        break;
      end
      if (done_o) n_done++;
      if (mem_req_o) begin
        if (!in_req) begin
          in_req = 1'b1; wait_cnt = 0; held_step = step_o;
          delay = $urandom_range(max_d, min_d);
          n_req++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL %s unexpected_req step=%0d exp=none", name, step_o);
          end else begin
            if (step_o !== 6'(exp_q[0])) begin n_fail++; $display("FAIL %s req_step got=%0d exp=%0d", name, step_o, exp_q[0]); end
            void'(exp_q.pop_front());
          end
          n_tests++;
          if (mem_last_o !== (int'(step_o) == vlc - 1)) begin
            n_fail++; $display("FAIL %s req_last step=%0d got=%b exp=%b", name, step_o, mem_last_o, int'(step_o) == vlc - 1);
          end
        end else begin
          n_tests++;
          if (step_o !== held_step) begin n_fail++; $display("FAIL %s step_hold got=%0d exp=%0d", name, step_o, held_step); end
        end
        if (wait_cnt == delay) begin
          mem_ack_i = 1'b1;
          in_req    = 1'b0;
        end else begin
          wait_cnt++;
        end
      end else if (noise_ack) begin
        mem_ack_i = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
    end
    start_i = 1'b0; mem_ack_i = 1'b0;
    n_tests++;
    if (!finished) begin n_fail++; $display("FAIL %s timeout got=busy exp=idle", name); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s missing_reqs got=%0d exp=%0d", name, n_req, n_req + exp_q.size()); end
    n_tests++;
    if (n_done != 1) begin n_fail++; $display("FAIL %s done_count got=%0d exp=1", name, n_done); end
  endtask

  task automatic test_full_mask();
    run_seq("full_mask", 4, 64'hF, 2, 2, 1'b0, 1'b0);
  endtask

  task automatic test_sparse_mask();
    run_seq("sparse_mask", 4, 64'hA, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_empty();
    run_seq("vl_zero", 0, '1, 0, 0, 1'b0, 1'b0);
    run_seq("mask_zero", 4, 64'h0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_start();
    run_seq("busy_start", 2, 64'h3, 1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_clamp();
    run_seq("clamp", 100, '1, 0, 0, 1'b0, 1'b0);
  endtask

  // VL=8; abort together with the ack of element 2.
  task automatic test_abort();
    bit hit;
    hit = 1'b0;
    start_i = 1'b1; vl_i = 7'd8; mask_i = '1;
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      mem_ack_i = mem_req_o;
      if (mem_req_o && step_o == 6'd2) begin
        abort_i = 1'b1; hit = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    abort_i = 1'b0; mem_ack_i = 1'b0;
    n_tests++; if (!hit) begin n_fail++; $display("FAIL abort_reach got=no_step2 exp=step2"); end
    n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL abort_req got=%b exp=0", mem_req_o); end
    n_tests++; if (step_o !== 6'd0) begin n_fail++; $display("FAIL abort_step got=%0d exp=0", step_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done_o); end
      @(negedge clk);
    end
    run_seq("after_abort", 3, '1, 0, 0, 1'b0, 1'b0);
  endtask

  // Synchronous reset in the middle of a sequence clears everything.
  task automatic test_rst_mid();
    start_i = 1'b1; vl_i = 7'd8; mask_i = '1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if ({mem_req_o, mem_last_o, busy_o, done_o} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_flags got=%b exp=0000", {mem_req_o, mem_last_o, busy_o, done_o}); end
    n_tests++; if (step_o !== 6'd0) begin n_fail++; $display("FAIL rst_mid_step got=%0d exp=0", step_o); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      run_seq("random", int'($urandom_range(72, 0)), {$urandom, $urandom}, 0, 3, 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_mask();
    test_sparse_mask();
    test_empty();
    test_abort();
    test_busy_start();
    test_clamp();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
